sd_dat_block_reader: RTL
========================

Name: sd_dat_block_reader

Overview:
- Receive stage for SD 4-bit data transfers. It sits directly downstream of the SD DAT pin buffers and runs alongside the SD card initializer/command path.
- Once the card is initialized and a read command has been issued, it detects the data start bit and deserializes one block of nibbles into bytes.
- It checks the per-line CRC16 and the end bit, then reports status to the controlling logic.
- The byte stream feeds the downstream buffer/consumer; the card cannot be stalled, so the output has no backpressure.

Parameters:
- BLOCK_LEN_BYTES, 512, bytes per block; legal range 1..4096.
- TIMEOUT_TICKS, 65535, maximum sample ticks to wait for the start bit before flagging a timeout.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_en  in  1  one-cycle strobe marking the clk cycle in which sd_datIn is sampled (the sd_clk rising edge, supplied by the clock generator).
- sd_datIn  in  4  registered DAT[3:0] pin inputs.
- start  in  1  pulse that arms the reader for one block; ignored unless idle.
- busy  out  1  high from the accepted start until done.
- out_data  out  8  received byte.
- out_valid  out  1  one-cycle pulse when out_data is valid.
- done  out  1  one-cycle pulse at the end of the transfer, whether it succeeded or failed.
- crc_err  out  1  held status: CRC mismatch on at least one line.
- end_err  out  1  held status: the end bit was not all ones.
- timeout_err  out  1  held status: no start bit arrived within TIMEOUT_TICKS.

Behaviour:
- Reset values: busy, out_valid and done are 0. out_data is 0x00. All three error flags are 0. The FSM is in IDLE.
- Reset asserted mid-transfer returns the block to IDLE on the next edge and discards any partial byte.
- Only clk cycles with sample_en=1 advance the DAT-related state. In all other cycles, data, CRC and counters hold.
- FSM states: IDLE, WAIT_START, DATA, CRC, END.
- IDLE:
  - start=1 moves to WAIT_START.
  - On that transition: busy=1, all error flags clear, tick counter=0, nibble counter=0, all four CRC registers=0x0000.
  - start while busy has no effect.
- WAIT_START, on each sample tick:
  - sd_datIn==4'b0000 moves to DATA. The start bit is not CRC'd.
  - Any other value: tick counter increments. When it reaches TIMEOUT_TICKS (checked before the increment), set timeout_err, pulse done, go to IDLE.
  - A partial start (some lines low, others high) counts as not-started.
- DATA:
  - 2*BLOCK_LEN_BYTES sample ticks.
  - Each DAT[i] bit is shifted into crc[i]: CRC-16-CCITT, poly x^16+x^12+x^5+1, init 0, MSB-first.
  - Even nibble index is the high nibble (DAT[3] = bit 7). Odd nibble index is the low nibble.
  - out_valid pulses one clk after the tick that completes the byte, i.e. registered output with latency 1.
  - After the last nibble, move to CRC.
- CRC:
  - 16 ticks. On each tick, compare DAT[i] with the MSB of crc[i], then shift crc[i] left.
  - Any mismatch sets crc_err (sticky for the transfer).
  - Then move to END.
- END:
  - 1 tick. sd_datIn != 4'b1111 sets end_err.
  - Pulse done, clear busy, go to IDLE.
  - The error flags hold their values until the next accepted start.
- done and the final out_valid never coincide. The last byte is emitted at least 17 ticks before done.
- Counter widths:
  - Nibble counter: clog2(2*BLOCK_LEN_BYTES+1).
  - Tick counter: clog2(TIMEOUT_TICKS+1).
  - CRC bit counter: 4 bits.
- Data bytes are emitted even if the CRC later fails; the consumer discards them on crc_err.

Decomposition:
- Shared package/header holds:
  - FSM state encoding.
  - CRC16 polynomial constant 16'h1021.
  - Bus-width constant 4.
- Natural sub-module: sd_crc16_serial. It holds one line's 16-bit CRC register with clear, shift-enable, data-bit input, and an MSB output. It is instantiated 4 times with a generate loop.

Test Plan:
- Nominal block: BLOCK_LEN_BYTES=1, data 0xA5. DAT nibbles are 4'hA then 4'h5, followed by CRCs from the bench reference model and end 4'hF. Required: a single out_valid with out_data=0xA5, done 17 ticks later, all error flags 0.
- Full block: 512 bytes of incrementing data 0x00..0xFF repeated, sample_en every 4th clk. Required: 512 out_valid pulses in order, no crc_err, busy high throughout.
- CRC fault: as the nominal block, but flip bit 5 of the CRC on DAT[2]. Required: data still emitted, crc_err=1 at done, end_err=0.
- Timeout: TIMEOUT_TICKS=8, DAT held 4'hF after start. Required: done plus timeout_err on tick 8, no out_valid, busy back to 0.
- End-bit / partial start: DAT=4'b0111 for 3 ticks (ignored), then a valid block with end nibble 4'hE. Required: correct bytes, end_err=1.
- Reset mid-DATA after 100 bytes, then a new start and a full block. Required: outputs cleared on reset, flags clear, second block received cleanly; a start pulsed during busy is ignored.

Source files
------------

// File: rtl/sd_dat_block_reader_pkg.sv
// Shared constants and FSM encoding for the SD 4-bit data block reader.
package sd_dat_block_reader_pkg;
  localparam int DAT_W = 4;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_END
  } state_e;
endpackage

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC-16-CCITT register for one DAT line, MSB first.
module sd_crc16_serial
  import sd_dat_block_reader_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic d_i,
  output logic msb_o
);
  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        fb;

  // Feeding the received CRC bit back in makes fb zero on a match,
  // so the CRC phase reduces to a plain left shift.
  always_comb begin
    fb    = d_i ^ crc_q[15];
    crc_d = {crc_q[14:0], 1'b0} ^ ({16{fb}} & CRC16_POLY);
  end

  always_ff @(posedge clk) begin
    if (rst)        crc_q <= '0;
    else if (clr_i) crc_q <= '0;
    else if (en_i)  crc_q <= crc_d;
  end

  assign msb_o = crc_q[15];
endmodule

// File: rtl/sd_dat_block_reader.sv
// SD 4-bit DAT receive stage: start detect, nibble-to-byte, CRC16 and end-bit check.
module sd_dat_block_reader
  import sd_dat_block_reader_pkg::*;
#(
  parameter int BLOCK_LEN_BYTES = 512,
  parameter int TIMEOUT_TICKS   = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [DAT_W-1:0] sd_datIn,
  input  logic             start,
  output logic             busy,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             done,
  output logic             crc_err,
  output logic             end_err,
  output logic             timeout_err
);
  localparam int NW = $clog2(2*BLOCK_LEN_BYTES+1);
  localparam int TW = $clog2(TIMEOUT_TICKS+1);
  localparam logic [NW-1:0] NIB_LAST = NW'(2*BLOCK_LEN_BYTES-1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS-1);

  state_e           state_q;
  logic [NW-1:0]    nib_q;
  logic [TW-1:0]    tick_q;
  logic [3:0]       bit_q;
  logic [3:0]       hi_q;
  logic             busy_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             done_q;
  logic             crc_err_q;
  logic             end_err_q;
  logic             to_err_q;
  logic             crc_clr;
  logic             crc_en;
  logic [DAT_W-1:0] crc_msb;

  assign crc_clr = (state_q == S_IDLE) && start;
  assign crc_en  = sample_en &&
                   ((state_q == S_DATA) || (state_q == S_CRC));

  for (genvar i = 0; i < DAT_W; i++) begin : g_crc
    sd_crc16_serial u_crc (
      .clk   (clk),
      .rst   (rst),
      .clr_i (crc_clr),
      .en_i  (crc_en),
      .d_i   (sd_datIn[i]),
      .msb_o (crc_msb[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      nib_q     <= '0;
      tick_q    <= '0;
      bit_q     <= '0;
      hi_q      <= '0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q   <= S_WAIT_START;
          busy_q    <= 1'b1;
          crc_err_q <= 1'b0;
          end_err_q <= 1'b0;
          to_err_q  <= 1'b0;
          tick_q    <= '0;
          nib_q     <= '0;
        end
        S_WAIT_START: if (sample_en) begin
          if (sd_datIn == '0) begin
            state_q <= S_DATA;
          end else if (tick_q == TO_LAST) begin
            to_err_q <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        S_DATA: if (sample_en) begin
          // Even nibble index carries the high half of the byte.
          if (!nib_q[0]) begin
            hi_q <= sd_datIn;
          end else begin
            data_q  <= {hi_q, sd_datIn};
            valid_q <= 1'b1;
          end
          if (nib_q == NIB_LAST) begin
            nib_q   <= '0;
            bit_q   <= '0;
            state_q <= S_CRC;
          end else begin
            nib_q <= nib_q + 1'b1;
          end
        end
        S_CRC: if (sample_en) begin
          if (sd_datIn != crc_msb) crc_err_q <= 1'b1;
          if (bit_q == 4'hF) state_q <= S_END;
          else               bit_q   <= bit_q + 1'b1;
        end
        S_END: if (sample_en) begin
          end_err_q <= (sd_datIn != 4'hF);
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign done        = done_q;
  assign crc_err     = crc_err_q;
  assign end_err     = end_err_q;
  assign timeout_err = to_err_q;
endmodule
